// File: rtl/alu_hs_iter.sv
// Handshaked ALU: single-cycle arithmetic/logic/compare/shift ops with a
// one-deep output register, plus an iterative restoring divider for div.
module alu_hs_iter #(
  parameter int N          = 16,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   alu_func,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         carry,
  output logic         zero,
  output logic         div_by_zero,
  output logic [1:0]   op_class
);

  localparam int SW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam logic [SW:0] N_W = (SW + 1)'(N);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_XNOR = 4'b1001;
  localparam logic [3:0] OP_EQ   = 4'b1010;
  localparam logic [3:0] OP_GT   = 4'b1011;
  localparam logic [3:0] OP_LT   = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1101;
  localparam logic [3:0] OP_SLL  = 4'b1110;
  localparam logic [3:0] OP_ROL  = 4'b1111;

  typedef enum logic {IDLE, DIV} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   dvsr_q, dvsr_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   result_q, result_d;
  logic [N-1:0]   result_hi_q, result_hi_d;
  logic           carry_q, carry_d;
  logic           zero_q, zero_d;
  logic           dbz_q, dbz_d;
  logic [1:0]     op_class_q, op_class_d;

  function automatic logic [1:0] class_of(input logic [3:0] f);
    if (f <= OP_DIV)       return 2'b00;
    else if (f <= OP_XNOR) return 2'b01;
    else if (f <= OP_LT)   return 2'b10;
    else                   return 2'b11;
  endfunction

  // Single-cycle datapath
  logic [N:0]     add_w;
  logic [N:0]     sub_w;
  logic [2*N-1:0] mul_w;
  logic [SW-1:0]  shamt;
  logic [SW:0]    rsh;
  logic [N-1:0]   rol_w;
  logic           eq_w, gt_w, lt_w;

  assign add_w = {1'b0, A} + {1'b0, B};
  assign sub_w = {1'b0, A} - {1'b0, B};
  assign mul_w = {{N{1'b0}}, A} * {{N{1'b0}}, B};
  assign shamt = B[SW-1:0];
  assign rsh   = N_W - {1'b0, shamt};
  assign rol_w = (A << shamt) | (A >> rsh);
  assign eq_w  = (A == B);
  assign gt_w  = SIGNED_CMP ? ($signed(A) > $signed(B)) : (A > B);
  assign lt_w  = SIGNED_CMP ? ($signed(A) < $signed(B)) : (A < B);

  logic [N-1:0] alu_lo, alu_hi;
  logic         alu_c, alu_dbz;

  always_comb begin
    alu_lo  = '0;
    alu_hi  = '0;
    alu_c   = 1'b0;
    alu_dbz = 1'b0;
    case (alu_func)
      OP_ADD:  begin alu_lo = add_w[N-1:0]; alu_c = add_w[N]; end
      OP_SUB:  begin alu_lo = sub_w[N-1:0]; alu_c = sub_w[N]; end
      OP_MUL:  begin alu_lo = mul_w[N-1:0]; alu_hi = mul_w[2*N-1:N]; end
      // Only reaches the output path when B==0; nonzero divisors go to DIV.
      OP_DIV:  begin alu_lo = '1; alu_hi = A; alu_dbz = 1'b1; end
      OP_AND:  alu_lo = A & B;
      OP_OR:   alu_lo = A | B;
      OP_NAND: alu_lo = ~(A & B);
      OP_NOR:  alu_lo = ~(A | B);
      OP_XOR:  alu_lo = A ^ B;
      OP_XNOR: alu_lo = ~(A ^ B);
      OP_EQ:   alu_lo = eq_w ? N'(1) : '0;
      OP_GT:   alu_lo = gt_w ? N'(2) : '0;
      OP_LT:   alu_lo = lt_w ? N'(3) : '0;
      OP_SRL:  alu_lo = A >> shamt;
      OP_SLL:  alu_lo = A << shamt;
      OP_ROL:  alu_lo = rol_w;
      default: alu_lo = '0;
    endcase
  end

  // Restoring divider step: dividend bits shift out of quo_q into the remainder.
  logic [N:0]   rem_shift;
  logic         rem_ge;
  logic [N-1:0] rem_diff;
  logic [N-1:0] rem_step;
  logic [N-1:0] quo_step;

  assign rem_shift = {rem_q, quo_q[N-1]};
  assign rem_ge    = (rem_shift >= {1'b0, dvsr_q});
  assign rem_diff  = rem_shift[N-1:0] - dvsr_q;
  assign rem_step  = rem_ge ? rem_diff : rem_shift[N-1:0];
  assign quo_step  = {quo_q[N-2:0], rem_ge};

  logic accept, div_start;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign div_start = accept && (alu_func == OP_DIV) && (B != '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    dbz_d       = dbz_q;
    op_class_d  = op_class_q;
    case (state_q)
      IDLE: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (div_start) begin
          state_d = DIV;
          cnt_d   = CW'(N);
          rem_d   = '0;
          quo_d   = A;
          dvsr_d  = B;
        end else if (accept) begin
          out_valid_d = 1'b1;
          result_d    = alu_lo;
          result_hi_d = alu_hi;
          carry_d     = alu_c;
          zero_d      = (alu_lo == '0);
          dbz_d       = alu_dbz;
          op_class_d  = class_of(alu_func);
        end
      end
      DIV: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          rem_d = rem_step;
          quo_d = quo_step;
        end else begin
          // Output register is guaranteed empty here: DIV is only entered when it drains.
          state_d     = IDLE;
          out_valid_d = 1'b1;
          result_d    = quo_q;
          result_hi_d = rem_q;
          carry_d     = 1'b0;
          zero_d      = (quo_q == '0);
          dbz_d       = 1'b0;
          op_class_d  = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      op_class_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
      op_class_q  <= op_class_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;
  assign op_class    = op_class_q;

endmodule
